// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared types and constants for the data memory responder.
// Rev 1.0 : initial release.
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEPTH_DEFAULT       = 256;
    localparam int WAIT_CYCLES_DEFAULT = 0;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int WORD_LSB = 2;   // byte offset bits within a 32-bit word
    localparam int CNT_W    = 4;   // wait counter covers 0..15

endpackage

`default_nettype wire

// File: rtl/data_ram.sv
// ============================================================================
// data_ram : single-port word RAM, synchronous write and read, no reset.
// Rev 1.0 : initial release.
// ============================================================================
`default_nettype none

module data_ram
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder : memory-stage load/store responder with fixed latency.
// Rev 1.0 : initial release.
// ============================================================================
`default_nettype none

module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_w_en,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                w_en_q, w_en_d;

    logic                fault;
    logic                issue;
    logic                ram_en;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_rdata;

    // Misaligned, or any word-index bit above the RAM's index range set.
    assign fault = (addr_q[WORD_LSB-1:0] != '0) ||
                   (addr_q[ADDR_W-1:WORD_LSB+IDX_W] != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        w_en_d  = w_en_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    w_en_d  = req_w_en;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    issue   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            w_en_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            w_en_q  <= w_en_d;
        end
    end

    assign ram_en = issue && !fault;
    assign ram_we = issue && w_en_q && !fault;

    data_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_data_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (addr_q[WORD_LSB +: IDX_W]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && fault;
    assign rsp_rdata = (rsp_valid && !fault && !w_en_q) ? ram_rdata : '0;
    // The response cycle releases the pipeline unless a new request is already waiting.
    assign stall     = (state_q == WAIT) || req_valid;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with WAIT_CYCLES=0 and one with WAIT_CYCLES=3.
`default_nettype none

module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_w_en = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        ready0, valid0, err0, stall0;
    logic [31:0] rdata0;
    logic        ready3, valid3, err3, stall3;
    logic [31:0] rdata3;

    logic        m_ready, m_valid, m_err, m_stall;
    logic [31:0] m_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid && !sel),
        .req_ready (ready0),
        .req_w_en  (req_w_en),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (valid0),
        .rsp_rdata (rdata0),
        .rsp_err   (err0),
        .stall     (stall0)
    );

    data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid && sel),
        .req_ready (ready3),
        .req_w_en  (req_w_en),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (valid3),
        .rsp_rdata (rdata3),
        .rsp_err   (err3),
        .stall     (stall3)
    );

    assign m_ready = sel ? ready3 : ready0;
    assign m_valid = sel ? valid3 : valid0;
    assign m_err   = sel ? err3   : err0;
    assign m_stall = sel ? stall3 : stall0;
    assign m_rdata = sel ? rdata3 : rdata0;

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One request on the selected instance; returns response, latency and handshake violations.
    task automatic access(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output int lat, output int bad);
        int guard;
        bad = 0;
        lat = 0;
        rd  = '0;
        e   = 1'b0;
        guard = 0;
        @(negedge clk);
        sel = s; req_w_en = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        #1;
        while (!m_ready && guard < 20) begin
            if (!m_stall) bad++;
            @(negedge clk); #1;
            guard++;
        end
        if (!m_stall) bad++;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!m_valid && lat < 40) begin
            if (!m_stall || m_ready || m_rdata !== 32'h0 || m_err !== 1'b0) bad++;
            @(negedge clk);
            lat++;
        end
        if (m_valid) begin
            if (m_stall || m_ready) bad++;
            rd = m_rdata;
            e  = m_err;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          bad;

        #1;
        chk_vec("rst_valid", {31'h0, valid0}, 32'h0);
        chk_vec("rst_rdata", rdata0, 32'h0);
        chk_vec("rst_err",   {31'h0, err0},   32'h0);
        chk_vec("rst_stall", {31'h0, stall0}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_vec("rst_ready0", {31'h0, ready0}, 32'h1);
        chk_vec("rst_ready3", {31'h0, ready3}, 32'h1);
        chk_vec("idle_stall3", {31'h0, stall3}, 32'h0);

        // WAIT_CYCLES=0: store then load
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat, bad);
        chk_vec("st10_lat", 32'(lat), 32'd2);
        chk_vec("st10_err", {31'h0, e}, 32'h0);
        chk_vec("st10_rdata", rd, 32'h0);
        chk_vec("st10_hs", 32'(bad), 32'd0);
        access(1'b0, 1'b0, 32'h10, 32'h0, rd, e, lat, bad);
        chk_vec("ld10_lat", 32'(lat), 32'd2);
        chk_vec("ld10_rdata", rd, 32'hDEADBEEF);
        chk_vec("ld10_err", {31'h0, e}, 32'h0);

        // faults
        access(1'b0, 1'b0, 32'h12, 32'h0, rd, e, lat, bad);
        chk_vec("ld12_err", {31'h0, e}, 32'h1);
        chk_vec("ld12_rdata", rd, 32'h0);
        chk_vec("ld12_lat", 32'(lat), 32'd2);
        access(1'b0, 1'b1, 32'h0, 32'h11111111, rd, e, lat, bad);
        access(1'b0, 1'b1, 32'h402, 32'h00000BAD, rd, e, lat, bad);
        chk_vec("st402_err", {31'h0, e}, 32'h1);
        access(1'b0, 1'b1, 32'h400, 32'h00000BAD, rd, e, lat, bad);
        chk_vec("st400_err", {31'h0, e}, 32'h1);
        access(1'b0, 1'b0, 32'h0, 32'h0, rd, e, lat, bad);
        chk_vec("ld0_rdata", rd, 32'h11111111);
        chk_vec("ld0_err", {31'h0, e}, 32'h0);

        // last valid word
        access(1'b0, 1'b1, 32'h3FC, 32'hA5A5_5A5A, rd, e, lat, bad);
        chk_vec("st3fc_err", {31'h0, e}, 32'h0);
        access(1'b0, 1'b0, 32'h3FC, 32'h0, rd, e, lat, bad);
        chk_vec("ld3fc_rdata", rd, 32'hA5A5_5A5A);

        // back-to-back store/load
        access(1'b0, 1'b1, 32'h20, 32'h1, rd, e, lat, bad);
        access(1'b0, 1'b0, 32'h20, 32'h0, rd, e, lat, bad);
        chk_vec("b2b_rdata", rd, 32'h1);
        chk_vec("b2b_hs", 32'(bad), 32'd0);

        // WAIT_CYCLES=3
        access(1'b1, 1'b1, 32'h40, 32'hCAFE0003, rd, e, lat, bad);
        chk_vec("w3_st_lat", 32'(lat), 32'd5);
        chk_vec("w3_st_hs", 32'(bad), 32'd0);
        access(1'b1, 1'b0, 32'h40, 32'h0, rd, e, lat, bad);
        chk_vec("w3_ld_lat", 32'(lat), 32'd5);
        chk_vec("w3_ld_rdata", rd, 32'hCAFE0003);
        chk_vec("w3_ld_hs", 32'(bad), 32'd0);
        access(1'b1, 1'b1, 32'h30, 32'h5, rd, e, lat, bad);

        // reset in the middle of a store's wait period
        @(negedge clk);
        sel = 1'b1; req_w_en = 1'b1; req_addr = 32'h30; req_wdata = 32'h9; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_vec("mid_rst_valid", {31'h0, valid3}, 32'h0);
        chk_vec("mid_rst_stall", {31'h0, stall3}, 32'h0);
        chk_vec("mid_rst_rdata", rdata3, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_vec("mid_rst_ready", {31'h0, ready3}, 32'h1);
        access(1'b1, 1'b0, 32'h30, 32'h0, rd, e, lat, bad);
        chk_vec("ld30_after_rst", rd, 32'h5);
        access(1'b0, 1'b0, 32'h10, 32'h0, rd, e, lat, bad);
        chk_vec("ram_kept_rst", rd, 32'hDEADBEEF);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
